// File: rtl/ysyx_23060184_idu_pipe.sv
// Pipelined decode stage: one-entry ID register, RegFile read with writeback bypass,
// pending-write scoreboard for RAW/WAW blocking, and a registered ID/EX issue slot.
module ysyx_23060184_idu_pipe #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic [AW-1:0]   rf_raddr1,
   output logic [AW-1:0]   rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1,
   output logic [XLEN-1:0] out_rs2,
   output logic [AW-1:0]   out_rd,
   output logic            out_regwr,
   output logic            stall
);

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_OP      = 7'b0110011;
   localparam logic [6:0] OP_MISCMEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic            id_valid;
   logic [31:0]     id_inst;
   logic [XLEN-1:0] id_pc;
   logic [CNT_W-1:0] sb [NREG];

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [AW-1:0]   rs1, rs2, rd;
   logic            is_system;
   logic            chk_rs1, chk_rs2, regwr;
   logic            haz1, haz2, waw, hazard;
   logic            issue, load;
   logic [XLEN-1:0] op1, op2;
   logic [NREG-1:0] sb_inc, sb_dec;

   assign rs1       = id_inst[15+:AW];
   assign rs2       = id_inst[20+:AW];
   assign rd        = id_inst[7+:AW];
   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;
   assign load      = in_valid && in_ready;

   // Decode source/destination use, evaluate hazards and form the handshakes.
   // chk_rs* already exclude x0 so register 0 can never raise a hazard.
   always_comb begin
      opcode    = id_inst[6:0];
      funct3    = id_inst[14:12];
      is_system = (opcode == OP_SYSTEM);
      chk_rs1   = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL)
                  && !(is_system && (funct3 == 3'b000 || funct3[2]))
                  && (rs1 != '0);
      chk_rs2   = (opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_OP)
                  && (rs2 != '0);
      regwr     = (rd != '0)
                  && !(opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_MISCMEM)
                  && !(is_system && funct3 == 3'b000);
      haz1 = chk_rs1 &&
             (((sb[rs1] != '0) && !(wb_valid && wb_rd == rs1 && sb[rs1] == CNT_W'(1)))
              || (out_valid && out_regwr && out_rd == rs1));
      haz2 = chk_rs2 &&
             (((sb[rs2] != '0) && !(wb_valid && wb_rd == rs2 && sb[rs2] == CNT_W'(1)))
              || (out_valid && out_regwr && out_rd == rs2));
      waw  = regwr && ((sb[rd] == CNT_MAX) || (out_valid && out_regwr && out_rd == rd));
      hazard   = haz1 || haz2 || waw;
      issue    = id_valid && !hazard && (!out_valid || out_ready) && !flush;
      in_ready = (!id_valid || issue) && !flush;
      stall    = id_valid && !issue;
      op1 = (rs1 == '0) ? '0 : ((wb_valid && wb_rd == rs1) ? wb_data : rf_rdata1);
      op2 = (rs2 == '0) ? '0 : ((wb_valid && wb_rd == rs2) ? wb_data : rf_rdata2);
   end

   // ID register: flush kills the entry and blocks the load in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         id_valid <= 1'b0;
         id_inst  <= '0;
         id_pc    <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (load) begin
         id_valid <= 1'b1;
         id_inst  <= in_inst;
         id_pc    <= in_pc;
      end else if (issue) begin
         id_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_pc    <= '0;
         out_rs1   <= '0;
         out_rs2   <= '0;
         out_rd    <= '0;
         out_regwr <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_inst  <= id_inst;
         out_pc    <= id_pc;
         out_rs1   <= op1;
         out_rs2   <= op2;
         out_rd    <= rd;
         out_regwr <= regwr;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // A write becomes pending once EXU takes it; a slot killed by flush never counts.
   always_comb begin
      sb_inc = '0;
      sb_dec = '0;
      if (out_valid && out_ready && out_regwr && !flush) sb_inc[out_rd] = 1'b1;
      if (wb_valid && wb_rd != '0) sb_dec[wb_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) sb[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (sb_inc[i] && !sb_dec[i])
               sb[i] <= sb[i] + CNT_W'(1);
            else if (sb_dec[i] && !sb_inc[i] && sb[i] != '0)
               sb[i] <= sb[i] - CNT_W'(1);
         end
      end
   end

   // A writeback to a register with no pending write means the EXU misbehaved.
   always @(posedge clk) begin
      if (rstn && wb_valid && wb_rd != '0) assert (sb[wb_rd] != '0);
   end

endmodule

// File: tb/tb_ysyx_23060184_idu_pipe.sv
// Bench for the decode stage: directed hazard/flush/reset scenarios, then a random
// program checked against an in-order architectural register model.
module tb_ysyx_23060184_idu_pipe;

   localparam int NPROG = 80;
   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
   localparam logic [6:0] BRANCH = 7'b1100011, STORE = 7'b0100011, OPR = 7'b0110011;
   localparam logic [6:0] OPIMM = 7'b0010011, LOAD = 7'b0000011;
   localparam logic [6:0] MISCMEM = 7'b0001111, SYSTEM = 7'b1110011;

   logic        clk, rstn;
   logic        in_valid, in_ready;
   logic [31:0] in_inst, in_pc;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_inst, out_pc, out_rs1, out_rs2;
   logic [4:0]  out_rd;
   logic        out_regwr, stall;

   logic [31:0] regs [32];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
   } wb_t;

   ysyx_23060184_idu_pipe dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_regwr(out_regwr),
      .stall(stall)
   );

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], OPIMM};
   endfunction

   function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
      return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], OPR};
   endfunction

   function automatic logic [31:0] lui(input int rd, input logic [19:0] imm);
      return {imm, rd[4:0], LUI};
   endfunction

   function automatic bit reads1(input logic [31:0] inst);
      if (inst[6:0] == LUI || inst[6:0] == AUIPC || inst[6:0] == JAL) return 1'b0;
      if (inst[6:0] == SYSTEM && (inst[14:12] == 3'd0 || inst[14:12] >= 3'd4)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit reads2(input logic [31:0] inst);
      return inst[6:0] == BRANCH || inst[6:0] == STORE || inst[6:0] == OPR;
   endfunction

   function automatic bit writes(input logic [31:0] inst);
      if (inst[11:7] == 5'd0) return 1'b0;
      if (inst[6:0] == BRANCH || inst[6:0] == STORE || inst[6:0] == MISCMEM) return 1'b0;
      if (inst[6:0] == SYSTEM && inst[14:12] == 3'd0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   // The external RegFile writes at the edge; the bench mirrors that just after it.
   task automatic tick();
      @(posedge clk);
      #1;
      if (wb_valid && wb_rd != 5'd0) regs[wb_rd] = wb_data;
   endtask

   task automatic doReset();
      rstn = 1'b0;
      in_valid = 1'b0; in_inst = '0; in_pc = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   initial begin
      logic [31:0] p_inst [NPROG];
      logic [31:0] p_pc   [NPROG];
      logic [31:0] p_res  [NPROG];
      logic [31:0] p_rs1  [NPROG];
      logic [31:0] p_rs2  [NPROG];
      logic [31:0] arch   [32];
      wb_t wbq [$];
      int fed, fetched, issued, cyc, lastdue, due;
      logic [6:0] op;

      for (int i = 0; i < 32; i++) regs[i] = '0;
      doReset();
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_out_pc", out_pc, 0);
      checkOutput("rst_out_rs1", out_rs1, 0);
      checkOutput("rst_out_regwr", out_regwr, 0);

      // RAW on x1: the add waits for the producer's writeback and takes it by bypass.
      doReset();
      out_ready = 1'b1;
      applyStimulus(addi(1, 0, 5), 32'h100);
      #1 checkOutput("t1_in_ready", in_ready, 1);
      tick();
      applyStimulus(add(2, 1, 1), 32'h104);
      #1 checkOutput("t1_addi_issue", stall, 0);
      tick();
      in_valid = 1'b0;
      #1;
      checkOutput("t1_slot_valid", out_valid, 1);
      checkOutput("t1_slot_rd", out_rd, 1);
      checkOutput("t1_stall_slot", stall, 1);
      tick();
      #1;
      checkOutput("t1_slot_left", out_valid, 0);
      checkOutput("t1_stall_sb", stall, 1);
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
      #1 checkOutput("t1_bypass_issue", stall, 0);
      tick();
      wb_valid = 1'b0;
      #1;
      checkOutput("t1_add_valid", out_valid, 1);
      checkOutput("t1_add_rs1", out_rs1, 5);
      checkOutput("t1_add_rs2", out_rs2, 5);
      checkOutput("t1_add_pc", out_pc, 32'h104);
      applyStimulus(add(3, 1, 1), 32'h108);
      tick();
      in_valid = 1'b0;
      #1 checkOutput("t1_sb1_cleared", stall, 0);

      // Independent stream: one issue per cycle, first out_valid two cycles after in_valid.
      doReset();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c < 4) applyStimulus(addi(c + 1, 0, c), 32'h200 + 32'(4 * c));
         else in_valid = 1'b0;
         #1;
         if (c < 4) checkOutput("t2_in_ready", in_ready, 1);
         if (c >= 2) begin
            checkOutput("t2_out_valid", out_valid, 1);
            checkOutput("t2_out_pc", out_pc, 32'h200 + 32'(4 * (c - 2)));
         end else begin
            checkOutput("t2_out_idle", out_valid, 0);
         end
         tick();
      end

      // Backpressure: the slot holds steady and ID stops accepting once full.
      doReset();
      out_ready = 1'b1;
      applyStimulus(addi(1, 0, 1), 32'h300);
      tick();
      applyStimulus(addi(2, 0, 2), 32'h304);
      tick();
      out_ready = 1'b0;
      applyStimulus(addi(3, 0, 3), 32'h308);
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput("t3_hold_valid", out_valid, 1);
         checkOutput("t3_hold_pc", out_pc, 32'h300);
         checkOutput("t3_hold_inst", out_inst, addi(1, 0, 1));
         checkOutput("t3_in_blocked", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      #1 checkOutput("t3_release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1 checkOutput("t3_second_pc", out_pc, 32'h304);
      tick();
      #1 checkOutput("t3_third_pc", out_pc, 32'h308);
      checkOutput("t3_third_valid", out_valid, 1);
      tick();
      #1 checkOutput("t3_drained", out_valid, 0);

      // Flush with both stages full; the pending write to x6 must survive it.
      doReset();
      out_ready = 1'b1;
      applyStimulus(addi(6, 0, 1), 32'h400);
      tick();
      applyStimulus(addi(1, 0, 1), 32'h404);
      tick();
      applyStimulus(addi(2, 0, 1), 32'h408);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      checkOutput("t4_pre_valid", out_valid, 1);
      checkOutput("t4_pre_stall", stall, 1);
      flush = 1'b1;
      #1 checkOutput("t4_flush_in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      #1;
      checkOutput("t4_post_valid", out_valid, 0);
      checkOutput("t4_post_stall", stall, 0);
      checkOutput("t4_post_in_ready", in_ready, 1);
      applyStimulus(add(7, 6, 0), 32'h40c);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1 checkOutput("t4_sb_kept", stall, 1);
      tick();
      #1 checkOutput("t4_sb_kept2", stall, 1);
      wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
      #1 checkOutput("t4_wb_release", stall, 0);
      tick();
      wb_valid = 1'b0;
      #1;
      checkOutput("t4_issue_valid", out_valid, 1);
      checkOutput("t4_issue_rs1", out_rs1, 32'h66);

      // Four writers to x5: the fourth waits for a writeback once three are pending.
      doReset();
      out_ready = 1'b1;
      fed = 0;
      for (int c = 0; c < 20 && fed < 4; c++) begin
         applyStimulus(addi(5, 0, fed + 1), 32'h500 + 32'(4 * fed));
         #1;
         if (in_ready) fed++;
         tick();
      end
      in_valid = 1'b0;
      checkOutput("t5_fed", fed, 4);
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput("t5_cap_stall", stall, 1);
         checkOutput("t5_cap_in_ready", in_ready, 0);
         tick();
      end
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h7;
      tick();
      wb_valid = 1'b0;
      #1 checkOutput("t5_after_wb", stall, 0);
      tick();
      #1;
      checkOutput("t5_fourth_valid", out_valid, 1);
      checkOutput("t5_fourth_pc", out_pc, 32'h50c);

      // Async reset in the middle of a stall, then a clean restart.
      doReset();
      out_ready = 1'b1;
      applyStimulus(addi(1, 0, 5), 32'h600);
      tick();
      applyStimulus(add(2, 1, 1), 32'h604);
      tick();
      in_valid = 1'b0;
      tick();
      #1 checkOutput("t6_pre_stall", stall, 1);
      rstn = 1'b0;
      #1;
      checkOutput("t6_async_stall", stall, 0);
      checkOutput("t6_async_valid", out_valid, 0);
      checkOutput("t6_async_in_ready", in_ready, 1);
      checkOutput("t6_async_pc", out_pc, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      applyStimulus(add(2, 1, 1), 32'h608);
      tick();
      applyStimulus(lui(3, 20'h00010), 32'h60c);
      #1 checkOutput("t6_sb_zeroed", stall, 0);
      tick();
      in_valid = 1'b0;
      #1 checkOutput("t6_lui_no_wait", stall, 0);
      tick();
      #1;
      checkOutput("t6_lui_pc", out_pc, 32'h60c);
      checkOutput("t6_lui_rd", out_rd, 3);

      // Random program against an in-order register model with a delayed-writeback EXU.
      for (int i = 0; i < 32; i++) begin
         regs[i] = '0;
         arch[i] = '0;
      end
      for (int k = 0; k < NPROG; k++) begin
         case ($urandom_range(0, 9))
            0: op = LUI;     1: op = AUIPC;  2: op = JAL;    3: op = BRANCH;
            4: op = STORE;   5: op = OPR;    6: op = OPIMM;  7: op = LOAD;
            8: op = MISCMEM; default: op = SYSTEM;
         endcase
         p_inst[k] = {7'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), op};
         p_pc[k]  = 32'h8000_0000 + 32'(4 * k);
         p_res[k] = $urandom;
         p_rs1[k] = arch[p_inst[k][19:15]];
         p_rs2[k] = arch[p_inst[k][24:20]];
         if (writes(p_inst[k])) arch[p_inst[k][11:7]] = p_res[k];
      end
      doReset();
      fetched = 0; issued = 0; cyc = 0; lastdue = 0;
      wbq.delete();
      while ((issued < NPROG || wbq.size() != 0) && cyc < 3000) begin
         if (wbq.size() != 0 && wbq[0].due <= cyc) begin
            wb_valid = 1'b1; wb_rd = wbq[0].rd; wb_data = wbq[0].data;
            wbq.delete(0);
         end else begin
            wb_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if (fetched < NPROG) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_inst  = p_inst[fetched];
            in_pc    = p_pc[fetched];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            if (issued < NPROG) begin
               checkOutput("rand_pc", out_pc, p_pc[issued]);
               checkOutput("rand_inst", out_inst, p_inst[issued]);
               checkOutput("rand_rd", out_rd, p_inst[issued][11:7]);
               checkOutput("rand_regwr", out_regwr, writes(p_inst[issued]));
               if (reads1(p_inst[issued])) checkOutput("rand_rs1", out_rs1, p_rs1[issued]);
               if (reads2(p_inst[issued])) checkOutput("rand_rs2", out_rs2, p_rs2[issued]);
               if (writes(p_inst[issued])) begin
                  due = cyc + int'($urandom_range(1, 3));
                  if (due <= lastdue) due = lastdue + 1;
                  lastdue = due;
                  wbq.push_back('{rd: p_inst[issued][11:7], data: p_res[issued], due: due});
               end
            end else begin
               checkOutput("rand_extra_issue", out_pc, 32'hffff_ffff);
            end
            issued++;
         end
         if (in_valid && in_ready) fetched++;
         tick();
         cyc++;
      end
      wb_valid = 1'b0;
      in_valid = 1'b0;
      checkOutput("rand_all_issued", issued, NPROG);
      checkOutput("rand_wb_drained", wbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
